// File: rtl/cp0_unit.sv
// cp0_unit: MIPS CP0 coprocessor registers with exception/ERET commit,
// masked interrupt request, Count prescaler and registered fetch redirect.
// Optional build macro: CP0_TIMER_INT_EN routes Cause.TI into IP7/int_req.
module cp0_unit #(
  parameter int unsigned HW_INT_NUM = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_req,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;
  localparam logic [31:0] STATUS_RST = 32'h1040_0000;
  localparam logic [3:0]  PRESC_MAX  = 4'(COUNT_DIV - 1);

  logic [31:0]           count_q, compare_q, status_q, epc_q, badvaddr_q, new_pc_q;
  logic [31:0]           status_d, cause_w, count_inc;
  logic [HW_INT_NUM-1:0] hw_ip_q;
  logic [1:0]            sw_ip_q;
  logic [4:0]            exccode_q;
  logic [3:0]            presc_q;
  logic [7:0]            ip;
  logic                  ti_q, bd_q, flush_q;
  logic                  cnt_tick, wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = we && (waddr == 5'd9);
  assign wr_compare = we && (waddr == 5'd11);
  assign wr_status  = we && (waddr == 5'd12);
  assign wr_cause   = we && (waddr == 5'd13);
  assign wr_epc     = we && (waddr == 5'd14);
  assign cnt_tick   = (presc_q == PRESC_MAX);
  assign count_inc  = count_q + 32'd1;

  // Assemble pending-interrupt field: SW bits, sampled HW lines, optional timer
  always_comb begin
    ip = '0;
    ip[1:0] = sw_ip_q;
    ip[2 +: HW_INT_NUM] = hw_ip_q;
`ifdef CP0_TIMER_INT_EN
    ip[7] = ip[7] | ti_q;
`else
`endif
  end

  assign cause_w = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b00};
  assign int_req = status_q[0] & ~status_q[1] & |(ip & status_q[15:8]);

  // Status next value: MTC0 fields first, then commit events override EXL
  always_comb begin
    status_d = status_q;
    if (wr_status) status_d = wdata;
    if (exc_valid)  status_d[1] = 1'b1;
    else if (eret)  status_d[1] = 1'b0;
  end

  // MFC0 read mux (no bypass of same-cycle writes)
  always_comb begin
    rdata = '0;
    case (raddr)
      5'd8:    rdata = badvaddr_q;
      5'd9:    rdata = count_q;
      5'd11:   rdata = compare_q;
      5'd12:   rdata = status_q;
      5'd13:   rdata = cause_w;
      5'd14:   rdata = epc_q;
      5'd15:   rdata = PRID_VAL;
      5'd16:   rdata = CONFIG_VAL;
      default: rdata = '0;
    endcase
  end

  // Register state, timer, exception/ERET commit and redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      new_pc_q   <= '0;
      hw_ip_q    <= '0;
      sw_ip_q    <= '0;
      exccode_q  <= '0;
      presc_q    <= '0;
      ti_q       <= 1'b0;
      bd_q       <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      // a Count write both loads the counter and suppresses that cycle's increment
      if (wr_count) begin
        count_q <= wdata;
        presc_q <= '0;
      end else if (cnt_tick) begin
        count_q <= count_inc;
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 4'd1;
      end

      if (wr_compare) compare_q <= wdata;

      if (wr_compare)
        ti_q <= 1'b0;
      else if (cnt_tick && !wr_count && (count_inc == compare_q) && (compare_q != '0))
        ti_q <= 1'b1;

      hw_ip_q  <= hw_int;
      status_q <= status_d;
      if (wr_cause) sw_ip_q <= wdata[9:8];

      // nested exceptions (EXL already set) keep the original EPC/BD
      if (exc_valid && !status_q[1]) begin
        epc_q <= exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_q  <= exc_bd;
      end else if (wr_epc) begin
        epc_q <= wdata;
      end

      if (exc_valid) begin
        exccode_q <= exc_code;
        if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr_q <= exc_badvaddr;
      end

      flush_q <= exc_valid | eret;
      if (exc_valid)  new_pc_q <= EXC_VECTOR;
      else if (eret)  new_pc_q <= epc_q;
    end
  end

  assign flush    = flush_q;
  assign new_pc   = new_pc_q;
  assign status_o = status_q;
  assign cause_o  = cause_w;
  assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (default parameters).
module tb_cp0_unit;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] PRID = 32'h004C_0102;

  logic        clk = 1'b0;
  logic        rst, we, exc_valid, exc_bd, eret;
  logic [4:0]  waddr, raddr, exc_code;
  logic [31:0] wdata, exc_pc, exc_badvaddr;
  logic [5:0]  hw_int;
  logic [31:0] rdata, new_pc, status_o, cause_o, epc_o;
  logic        int_req, flush;

  int n_cmp = 0;
  int n_err = 0;
  bit found;

  always #5 clk = ~clk;

  cp0_unit #(
    .HW_INT_NUM(6),
    .COUNT_DIV (2),
    .EXC_VECTOR(VEC),
    .PRID_VAL  (PRID)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .int_req(int_req), .flush(flush), .new_pc(new_pc),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_exc(input logic [4:0] code, input logic [31:0] pc,
                        input logic bd, input logic [31:0] bva, input logic with_eret);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_badvaddr = bva; eret = with_eret;
    tick();
    exc_valid = 1'b0; eret = 1'b0; exc_bd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; hw_int = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr = '0; eret = 1'b0;
    tick(); tick();

    // reset state (still in reset, so Count is frozen at 0)
    rd("rst_status", 5'd12, 32'h1040_0000);
    rd("rst_prid",   5'd15, PRID);
    rd("rst_config", 5'd16, 32'h0000_8000);
    rd("rst_cause",  5'd13, 32'h0);
    rd("rst_count",  5'd9,  32'h0);
    rd("rst_unk",    5'd3,  32'h0);
    chk("rst_flush",  {31'b0, flush}, 32'h0);
    chk("rst_newpc",  new_pc, 32'h0);
    rst = 1'b0;

    // timer: Compare=5, Count=0, Status IE|IM7
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9,  32'h0);
    rd("cnt_load", 5'd9, 32'h0);
    mtc0(5'd11, 32'd5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      raddr = 5'd13;
      #1;
      if (rdata[30]) found = 1'b1;
    end
    chk("ti_set", {31'b0, found}, 32'h1);
    rd("ti_count", 5'd9, 32'd5);
`ifdef CP0_TIMER_INT_EN
    rd("ti_cause", 5'd13, 32'h4000_8000);
    chk("ti_intreq", {31'b0, int_req}, 32'h1);
`else
    rd("ti_cause", 5'd13, 32'h4000_0000);
    chk("ti_intreq", {31'b0, int_req}, 32'h0);
`endif
    // Compare=0 write: same-cycle read returns old value, TI clears
    we = 1'b1; waddr = 5'd11; wdata = 32'h0;
    rd("cmp_nobypass", 5'd11, 32'd5);
    tick();
    we = 1'b0;
    rd("ti_clear", 5'd13, 32'h0);
    chk("ti_clr_int", {31'b0, int_req}, 32'h0);

    // Count wrap with COUNT_DIV=2
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd("wrap_load", 5'd9, 32'hFFFF_FFFF);
    tick(); tick();
    rd("wrap_zero", 5'd9, 32'h0);

    // address error in a delay slot
    mtc0(5'd12, 32'h0);
    do_exc(5'd4, 32'h8000_0104, 1'b1, 32'h1234_5679, 1'b0);
    rd("ade_epc",    5'd14, 32'h8000_0100);
    rd("ade_cause",  5'd13, 32'h8000_0010);
    rd("ade_bva",    5'd8,  32'h1234_5679);
    rd("ade_status", 5'd12, 32'h0000_0002);
    chk("ade_flush", {31'b0, flush}, 32'h1);
    chk("ade_newpc", new_pc, VEC);
    tick();
    chk("ade_flush_end", {31'b0, flush}, 32'h0);

    // nested overflow with EXL=1
    do_exc(5'd12, 32'h8000_0200, 1'b0, 32'h0000_DEAD, 1'b0);
    rd("nest_cause", 5'd13, 32'h8000_0030);
    rd("nest_epc",   5'd14, 32'h8000_0100);
    rd("nest_bva",   5'd8,  32'h1234_5679);
    chk("nest_flush", {31'b0, flush}, 32'h1);
    chk("nest_newpc", new_pc, VEC);
    tick();

    // ERET back to EPC
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd("eret_status", 5'd12, 32'h0);
    chk("eret_flush", {31'b0, flush}, 32'h1);
    chk("eret_newpc", new_pc, 32'h8000_0100);
    tick();
    chk("eret_flush_end", {31'b0, flush}, 32'h0);

    // ERET together with an exception: exception wins
    do_exc(5'd8, 32'h8000_0300, 1'b0, 32'h0, 1'b1);
    rd("both_status", 5'd12, 32'h0000_0002);
    rd("both_epc",    5'd14, 32'h8000_0300);
    rd("both_cause",  5'd13, 32'h0000_0020);
    chk("both_newpc", new_pc, VEC);

    // back-to-back commits: ERET then trap
    eret = 1'b1;
    tick();
    eret = 1'b0;
    exc_valid = 1'b1; exc_code = 5'd13; exc_pc = 32'h8000_0400;
    chk("b2b_flush1", {31'b0, flush}, 32'h1);
    chk("b2b_newpc1", new_pc, 32'h8000_0300);
    tick();
    exc_valid = 1'b0;
    chk("b2b_flush2", {31'b0, flush}, 32'h1);
    chk("b2b_newpc2", new_pc, VEC);
    rd("b2b_epc", 5'd14, 32'h8000_0400);

    // hardware interrupt on hw_int[2] (IP4), IM4|IE with EXL cleared
    mtc0(5'd12, 32'h0000_1001);
    hw_int = 6'b000100;
    #1;
    chk("hw_pre_int", {31'b0, int_req}, 32'h0);
    tick();
    chk("hw_int_req", {31'b0, int_req}, 32'h1);
    rd("hw_cause", 5'd13, 32'h0000_1034);
    mtc0(5'd12, 32'h0000_1003);
    chk("hw_exl_mask", {31'b0, int_req}, 32'h0);

    // software interrupt: only Cause[9:8] writable
    hw_int = '0;
    mtc0(5'd12, 32'h0000_0101);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("sw_cause", 5'd13, 32'h0000_0334);
    chk("sw_int_req", {31'b0, int_req}, 32'h1);

    // reset at the same edge as a commit clears the pending flush
    exc_valid = 1'b1; exc_code = 5'd9; rst = 1'b1;
    tick();
    exc_valid = 1'b0; rst = 1'b0;
    chk("rst_mid_flush", {31'b0, flush}, 32'h0);
    chk("rst_mid_newpc", new_pc, 32'h0);
    chk("rst_mid_status", status_o, 32'h1040_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Parametrised CP0 coprocessor block for the MIPS pipeline. It holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config, and services MTC0/MFC0. It commits exceptions and ERET in the memory stage, produces the masked interrupt request, and issues a registered flush plus redirect PC to the fetch stage. Relative to the previous CP0 it adds a parametrised interrupt width, a Count prescaler, EXL-nested exception rules, ERET handling and redirect generation.

## Interface
Parameters:
- HW_INT_NUM, 6, number of hardware interrupt lines (1..6), mapped to Cause[10 +: HW_INT_NUM]
- COUNT_DIV, 2, clock cycles per Count increment (1..16)
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC
- PRID_VAL, 32'h004C_0102, constant PRId value

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  MTC0 write enable
- waddr  in  5  MTC0 register number
- wdata  in  32  MTC0 data
- raddr  in  5  MFC0 register number
- rdata  out  32  MFC0 data, combinational
- hw_int  in  HW_INT_NUM  level hardware interrupts
- exc_valid  in  1  exception commits this cycle
- exc_code  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov, 13 Tr)
- exc_pc  in  32  PC of the excepting instruction
- exc_bd  in  1  excepting instruction is in a delay slot
- exc_badvaddr  in  32  faulting address for AdEL/AdES
- eret  in  1  ERET commits this cycle
- int_req  out  1  pending enabled interrupt, combinational
- flush  out  1  pipeline flush pulse, registered
- new_pc  out  32  redirect target, valid while flush=1
- status_o, cause_o, epc_o  out  32 each  register mirrors

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15 sel0, Config 16. Any other raddr reads 0. Writes to read-only or unknown registers are ignored.
- Writable fields:
  - Status: full word.
  - Cause: only IP[9:8] (software interrupts).
  - Count, Compare, EPC: full word.
- Cause[10 +: HW_INT_NUM] samples hw_int every cycle. Unused IP bits read 0.
- Prescaler:
  - Counts 0..COUNT_DIV-1; Count increments when it wraps.
  - Writing Count loads wdata and clears the prescaler.
- Timer: Cause.TI (bit 30) sets when Count==Compare at an increment and Compare!=0. A Compare write clears TI.
- int_req = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]).
- Exception commit (exc_valid=1):
  - ExcCode <= exc_code; Status.EXL <= 1.
  - If EXL was 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - BadVAddr <= exc_badvaddr only for codes 4 and 5.
- ERET: Status.EXL <= 0.
- Redirect: flush=1 the cycle after an exception or ERET commit. new_pc = EXC_VECTOR for an exception, or the EPC value current at commit for ERET.

## Timing
- Reset values:
  - Status 32'h1040_0000; all other registers 0, PRId = PRID_VAL, Config 32'h0000_8000.
  - flush 0, new_pc 0, prescaler 0.
- MTC0 takes effect at the next edge. MFC0 in the same cycle returns the old value (no bypass).
- flush is a single-cycle pulse with latency 1 from commit. Back-to-back commits give back-to-back pulses.
- Simultaneous events:
  - exc_valid and eret: exception wins, ERET ignored.
  - exc_valid and MTC0 to EPC/Status/Cause: exception-updated fields win; other fields take the write.
  - MTC0 Compare and a Count match in the same cycle: TI=0.
  - MTC0 Count in the same cycle as an increment: the written value wins.
- Count wraps 32'hFFFF_FFFF -> 0 silently.
- Reset mid-operation clears any pending flush the same edge.

## Configuration
- CP0_TIMER_INT_EN:
  - Defined: TI is ORed into Cause.IP7 (bit 15), together with hw_int[5] when HW_INT_NUM=6, and therefore contributes to int_req.
  - Undefined: TI still sets and clears and is visible in Cause[30], but never reaches IP7 or int_req.

## Test plan
- Reset, then MFC0 of 12/15/16 -> 32'h1040_0000 / PRID_VAL / 32'h0000_8000; flush=0.
- COUNT_DIV=2, MTC0 Compare=5, Status=32'h0000_8001, with CP0_TIMER_INT_EN -> TI and int_req=1 within 10 cycles of the Count increment to 5. MTC0 Compare=0 -> TI=0 next cycle.
- exc_valid, code 4, exc_pc=32'h8000_0104, exc_bd=1, badvaddr=32'h1234_5679 -> EPC=32'h8000_0100, BD=1, BadVAddr=32'h1234_5679, EXL=1; next cycle flush=1, new_pc=EXC_VECTOR.
- With EXL=1, a second exception (code 12, pc 32'h8000_0200) -> ExcCode=12, EPC unchanged, flush pulses.
- eret with EPC=32'h8000_0100 -> EXL=0 next edge; flush=1, new_pc=32'h8000_0100. eret together with exc_valid -> EXL stays 1, new_pc=EXC_VECTOR.
- hw_int[2]=1, Status IM4=1, IE=1, EXL=0 -> int_req=1 the cycle after hw_int rises. Set EXL -> int_req=0.
